// File: rtl/apb_master_bridge_pkg.sv
// Shared APB definitions for the master bridge and its register slave.
// Holds the bridge FSM state type, the default bus widths, the command and
// response payload structs and the slave register map offsets.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    // Command payload presented by the command source
    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Response payload returned to the command source
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Register slave offsets; anything at or above REG_END is unmapped
    localparam logic [APB_ADDR_W-1:0] REG_CTRL    = APB_ADDR_W'(32'h00);
    localparam logic [APB_ADDR_W-1:0] REG_STATUS  = APB_ADDR_W'(32'h04);
    localparam logic [APB_ADDR_W-1:0] REG_DATA0   = APB_ADDR_W'(32'h08);
    localparam logic [APB_ADDR_W-1:0] REG_DATA1   = APB_ADDR_W'(32'h0C);
    localparam logic [APB_ADDR_W-1:0] REG_IRQ     = APB_ADDR_W'(32'h10);
    localparam logic [APB_ADDR_W-1:0] REG_SCRATCH = APB_ADDR_W'(32'h14);
    localparam logic [APB_ADDR_W-1:0] REG_END     = APB_ADDR_W'(32'h18);
    localparam int unsigned           REG_NUM     = 6;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a valid/ready command stream into single APB
// transfers and returns a valid/ready response.
// Ports:
//   PCLK, PRESET                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready is combinational)
//   cmd_addr/cmd_write/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB master outputs (registered)
//   PRDATA/PREADY/PSLVERR         APB slave returns
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_mst_state_e    state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              rsp_to_q,    rsp_to_d;

    // Only IDLE can take a command
    assign cmd_ready = (state_q == IDLE);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over a timeout firing in the same cycle
                if (PREADY) begin
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                    rsp_err_d   = PSLVERR;
                    rsp_to_d    = 1'b0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a simple register slave, a transaction-level
// model that predicts the cycle timeline and response of every command, and
// a per-cycle compare process.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int unsigned TIMEOUT_CYC = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- register slave ----------------
    function automatic bit addr_ok(input logic [31:0] a);
        return (a < REG_END) && (a[1:0] == 2'b00);
    endfunction

    logic [31:0] slv_regs [8];
    int          slv_wcnt = 0;
    int          slv_waits = 0;
    bit          slv_hang = 1'b0;
    bit          slv_load = 1'b0;
    logic [31:0] junk = 32'hBAD0_0BAD;
    logic        noise = 1'b0;

    assign PREADY  = PSEL && PENABLE && !slv_hang && (slv_wcnt == slv_waits);
    assign PRDATA  = (addr_ok(PADDR) && !PWRITE) ? slv_regs[PADDR[4:2]] : junk;
    assign PSLVERR = PREADY ? !addr_ok(PADDR) : noise;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) slv_wcnt <= slv_wcnt + 1;
        else                            slv_wcnt <= 0;
        if (slv_load) begin
            for (int i = 0; i < 8; i++) slv_regs[i] <= 32'h1000_0000 + i;
        end else if (PSEL && PENABLE && PREADY && PWRITE && addr_ok(PADDR)) begin
            slv_regs[PADDR[4:2]] <= PWDATA;
        end
    end

    always @(negedge PCLK) begin
        junk  <= $urandom;
        noise <= 1'($urandom_range(0, 1));
    end

    // ---------------- transaction model ----------------
    logic [31:0] m_regs [8];
    int          m_n = -100;     // accept cycle
    int          m_a = 0;        // number of ACCESS cycles
    int          m_trsp = -90;   // first RESP cycle
    int          m_c = -50;      // last busy cycle (response consumed or reset)
    apb_cmd_t    m_cmd;
    apb_rsp_t    m_rsp;
    int          last_lat;
    int          last_pen;
    apb_rsp_t    last_rsp;

    // Per-cycle compare, sampled 1 time unit after the active edge
    initial begin
        forever begin
            @(posedge PCLK);
            cyc++;
            #1;
            if (chk_en) begin
                bit act, e_psel, e_pen, e_rv;
                act    = (cyc > m_n) && (cyc <= m_c);
                e_psel = act && (cyc <= m_n + 1 + m_a);
                e_pen  = act && (cyc >= m_n + 2) && (cyc <= m_n + 1 + m_a);
                e_rv   = act && (cyc >= m_trsp);
                chk("cmd_ready", 64'(cmd_ready), 64'(!act));
                chk("psel",      64'(PSEL),      64'(e_psel));
                chk("penable",   64'(PENABLE),   64'(e_pen));
                chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
                if (e_psel) begin
                    chk("paddr",  64'(PADDR),  64'(m_cmd.addr));
                    chk("pwrite", 64'(PWRITE), 64'(m_cmd.write));
                    chk("pwdata", 64'(PWDATA), 64'(m_cmd.wdata));
                end
                if (e_rv) begin
                    chk("rsp_rdata",   64'(rsp_rdata),   64'(m_rsp.rdata));
                    chk("rsp_err",     64'(rsp_err),     64'(m_rsp.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(m_rsp.timeout));
                end
            end
        end
    end

    // Issue one command; timeline and response come from the model.
    // rst_at >= 0 asserts PRESET that many cycles after acceptance.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input int waits, input bit hang, input int rdly, input int rst_at);
        bit to, aborted;
        @(negedge PCLK);
        slv_waits = waits;
        slv_hang  = hang;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        rsp_ready = 1'($urandom_range(0, 1));
        to = hang || (waits >= int'(TIMEOUT_CYC));
        m_cmd.addr  = a;
        m_cmd.write = w;
        m_cmd.wdata = d;
        if (to)               begin m_rsp.rdata = '0; m_rsp.err = 1'b1; m_rsp.timeout = 1'b1; end
        else if (!addr_ok(a)) begin m_rsp.rdata = '0; m_rsp.err = 1'b1; m_rsp.timeout = 1'b0; end
        else if (w)           begin m_rsp.rdata = '0; m_rsp.err = 1'b0; m_rsp.timeout = 1'b0; end
        else begin m_rsp.rdata = m_regs[a[4:2]]; m_rsp.err = 1'b0; m_rsp.timeout = 1'b0; end
        m_a    = to ? int'(TIMEOUT_CYC) : waits + 1;
        m_n    = cyc;
        m_trsp = cyc + 2 + m_a;
        m_c    = m_trsp + rdly;
        last_lat = -1;
        last_pen = 0;
        last_rsp = '0;
        aborted  = 1'b0;
        do begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_wdata = $urandom;
            if (PENABLE) last_pen++;
            if (rsp_valid && last_lat < 0) last_lat = cyc - m_n;
            if (cyc == m_trsp) begin
                last_rsp.rdata = rsp_rdata;
                last_rsp.err = rsp_err;
                last_rsp.timeout = rsp_timeout;
            end
            if (cyc >= m_c)         rsp_ready = 1'b1;
            else if (cyc < m_trsp)  rsp_ready = 1'($urandom_range(0, 1));
            else                    rsp_ready = 1'b0;
            if (rst_at >= 0 && cyc == m_n + rst_at) begin
                PRESET  = 1'b1;
                m_c     = cyc;
                aborted = 1'b1;
            end
        end while (cyc < m_c);
        if (!aborted && !to && w && addr_ok(a)) m_regs[a[4:2]] = d;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int acc0, acc1;
        logic [31:0] ra;
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        slv_load = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h1000_0000 + i;
        repeat (3) @(negedge PCLK);
        slv_load = 1'b0;

        // Reset state
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        PRESET = 1'b0;
        chk_en = 1'b1;

        // Write then read back, zero wait states
        do_txn(REG_SCRATCH, 1'b1, 32'hDEADBEEF, 0, 1'b0, 0, -1);
        chk("wr_lat", 64'(last_lat), 64'd3);
        chk("wr_err", 64'(last_rsp.err), 64'd0);
        do_txn(REG_SCRATCH, 1'b0, 32'h0, 0, 1'b0, 0, -1);
        chk("rd_lat", 64'(last_lat), 64'd3);
        chk("rd_data", 64'(last_rsp.rdata), 64'hDEADBEEF);
        chk("rd_err", 64'(last_rsp.err), 64'd0);

        // Unmapped address
        do_txn(32'h18, 1'b0, 32'h0, 0, 1'b0, 0, -1);
        chk("bad_err", 64'(last_rsp.err), 64'd1);
        chk("bad_to", 64'(last_rsp.timeout), 64'd0);
        chk("bad_rdata", 64'(last_rsp.rdata), 64'd0);

        // Three wait states
        do_txn(REG_DATA0, 1'b1, 32'h1234_5678, 3, 1'b0, 0, -1);
        chk("ws_penable_cycles", 64'(last_pen), 64'd4);
        chk("ws_lat", 64'(last_lat), 64'd6);
        chk("ws_err", 64'(last_rsp.err), 64'd0);

        // Hung slave: timeout, then a normal read of 0x00
        do_txn(REG_CTRL, 1'b1, 32'h5555_AAAA, 0, 1'b1, 0, -1);
        chk("to_penable_cycles", 64'(last_pen), 64'd16);
        chk("to_lat", 64'(last_lat), 64'd18);
        chk("to_err", 64'(last_rsp.err), 64'd1);
        chk("to_flag", 64'(last_rsp.timeout), 64'd1);
        do_txn(REG_CTRL, 1'b0, 32'h0, 0, 1'b0, 0, -1);
        chk("post_to_rdata", 64'(last_rsp.rdata), 64'h1000_0000);
        chk("post_to_err", 64'(last_rsp.err), 64'd0);

        // PREADY on the last allowed cycle completes; one more wait times out
        do_txn(REG_DATA1, 1'b0, 32'h0, TIMEOUT_CYC - 1, 1'b0, 0, -1);
        chk("edge_lat", 64'(last_lat), 64'd18);
        chk("edge_to", 64'(last_rsp.timeout), 64'd0);
        chk("edge_rdata", 64'(last_rsp.rdata), 64'h1000_0003);
        do_txn(REG_DATA1, 1'b0, 32'h0, TIMEOUT_CYC, 1'b0, 0, -1);
        chk("over_to", 64'(last_rsp.timeout), 64'd1);

        // Response backpressure
        do_txn(REG_STATUS, 1'b0, 32'h0, 0, 1'b0, 5, -1);
        chk("bp_rdata", 64'(last_rsp.rdata), 64'h1000_0001);

        // Reset during a wait-stated write
        do_txn(REG_DATA1, 1'b1, 32'hCAFE_F00D, 8, 1'b0, 0, 4);
        @(negedge PCLK);
        chk("mrst_psel", 64'(PSEL), 64'd0);
        chk("mrst_penable", 64'(PENABLE), 64'd0);
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
        PRESET = 1'b0;
        do_txn(REG_DATA1, 1'b0, 32'h0, 0, 1'b0, 0, -1);
        chk("mrst_no_write", 64'(last_rsp.rdata), 64'h1000_0003);

        // Back-to-back throughput
        do_txn(REG_IRQ, 1'b1, 32'h0000_00FF, 0, 1'b0, 0, -1);
        acc0 = m_n;
        do_txn(REG_IRQ, 1'b0, 32'h0, 0, 1'b0, 0, -1);
        acc1 = m_n;
        chk("b2b_period", 64'(acc1 - acc0), 64'd4);
        chk("b2b_rdata", 64'(last_rsp.rdata), 64'h0000_00FF);

        // Randomized traffic against the model
        for (int t = 0; t < 200; t++) begin
            int k, wt;
            k = int'($urandom_range(0, 9));
            if (k < 8)       ra = 32'(k * 4);
            else if (k == 8) ra = 32'(2 + 4 * $urandom_range(0, 5));
            else             ra = 32'h1000_0000 | $urandom;
            wt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 3));
            do_txn(ra, 1'($urandom_range(0, 1)), $urandom, wt,
                   ($urandom_range(0, 15) == 0), int'($urandom_range(0, 4)), -1);
            idle_gap(int'($urandom_range(0, 2)));
        end

        idle_gap(3);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
